// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB write-back inputs, decode read ports and forwarding/debug outputs
//   master: pipeline side (drives MEM/WB fields and read addresses, receives read data and wb_*)
//   slave : register file side
interface wb_regfile_if #(parameter int DATA_W = 8);
    logic              writeReg_i;
    logic [3:0]        opcode_i;
    logic [2:0]        regD_i;
    logic [DATA_W-1:0] alu_reg_i;
    logic [DATA_W-1:0] meDat_i;
    logic [DATA_W-1:0] data1_i;
    logic [2:0]        imm_i;
    logic [2:0]        rd_addr1_i;
    logic [2:0]        rd_addr2_i;
    logic [DATA_W-1:0] rd_data1_o;
    logic [DATA_W-1:0] rd_data2_o;
    logic              wb_en_o;
    logic [2:0]        wb_addr_o;
    logic [DATA_W-1:0] wb_data_o;
    logic [15:0]       retired_o;
    modport master (
        output writeReg_i, opcode_i, regD_i, alu_reg_i, meDat_i, data1_i, imm_i, rd_addr1_i, rd_addr2_i,
        input  rd_data1_o, rd_data2_o, wb_en_o, wb_addr_o, wb_data_o, retired_o
    );
    modport slave (
        input  writeReg_i, opcode_i, regD_i, alu_reg_i, meDat_i, data1_i, imm_i, rd_addr1_i, rd_addr2_i,
        output rd_data1_o, rd_data2_o, wb_en_o, wb_addr_o, wb_data_o, retired_o
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: write-back source select, 8-entry register file with write-first bypass, retire counter
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : MEM/WB inputs, two combinational read ports, wb_en/addr/data for forwarding, retired_o count
module wb_regfile #(
    parameter int         DATA_W = 8,
    parameter int         NREGS  = 8,
    parameter logic [3:0] LD_OP  = 4'h8,
    parameter logic [3:0] LI_OP  = 4'h9,
    parameter logic [3:0] MOV_OP = 4'hA
) (
    input logic        clk,
    input logic        rst_n,
    wb_regfile_if.slave bus
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] wb_data;
    logic              wb_en;
    always_comb begin
        wb_data = bus.opcode_i == LD_OP  ? bus.meDat_i :
                  bus.opcode_i == LI_OP  ? {{(DATA_W-3){1'b0}}, bus.imm_i} :
                  bus.opcode_i == MOV_OP ? bus.data1_i : bus.alu_reg_i;
    end
    // Gating with rst_n keeps the bypass off and drops an in-flight write while reset is held
    assign wb_en          = bus.writeReg_i & rst_n;
    assign bus.wb_en_o    = wb_en;
    assign bus.wb_addr_o  = bus.regD_i;
    assign bus.wb_data_o  = wb_data;
    assign bus.rd_data1_o = (wb_en && bus.rd_addr1_i == bus.regD_i) ? wb_data : regs[bus.rd_addr1_i];
    assign bus.rd_data2_o = (wb_en && bus.rd_addr2_i == bus.regD_i) ? wb_data : regs[bus.rd_addr2_i];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            bus.retired_o <= 16'h0000;
        end else if (wb_en) begin
            regs[bus.regD_i] <= wb_data;
            bus.retired_o    <= bus.retired_o + 16'd1;
        end
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file for the 8-bit pipelined core. Consumes the outputs of the MEM/WB pipeline register, selects the write-back value by opcode, commits it to an 8-entry register file on the clock edge, and serves two combinational read ports to decode with write-first bypass. It also exposes the current write-back port for the forwarding unit and keeps a retired-write counter for debug.

## Interface
Parameters:
- DATA_W, 8, register and datapath width
- NREGS, 8, number of architectural registers; address width is 3
- LD_OP, 4'h8, opcode whose write-back source is meDat_i
- LI_OP, 4'h9, opcode whose write-back source is imm_i zero-extended to DATA_W
- MOV_OP, 4'hA, opcode whose write-back source is data1_i

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- writeReg_i  in  1  write-back enable from MEM/WB
- opcode_i  in  4  opcode from MEM/WB
- regD_i  in  3  destination register index
- alu_reg_i  in  8  ALU result
- meDat_i  in  8  data-memory load data
- data1_i  in  8  first source operand value
- imm_i  in  3  immediate field
- rd_addr1_i, rd_addr2_i  in  3 each  decode read addresses
- rd_data1_o, rd_data2_o  out  8 each  read data, combinational
- wb_en_o  out  1  write-back active this cycle, combinational
- wb_addr_o  out  3  write-back destination, combinational
- wb_data_o  out  8  selected write-back value, combinational
- retired_o  out  16  count of committed register writes

## Operation
- Source select: opcode_i==LD_OP -> meDat_i; ==LI_OP -> {5'b0, imm_i}; ==MOV_OP -> data1_i; any other opcode -> alu_reg_i.
- wb_en_o = writeReg_i & rst_n. wb_addr_o = regD_i. wb_data_o = selected value, independent of writeReg_i.
- Commit: on posedge clk with wb_en_o=1, regs[regD_i] <= wb_data_o. All 8 registers are writable, including r0.
- Read: rd_dataN_o = (wb_en_o && rd_addrN_i==regD_i) ? wb_data_o : regs[rd_addrN_i]. Both ports bypass independently; both may hit the same address.
- Retire counter: +1 on each edge with wb_en_o=1; 16-bit wrap 16'hFFFF -> 16'h0000; no saturation.
- No stall or flush inputs; a bubble arrives as writeReg_i=0 and changes no state.

## Timing
- Reset (rst_n low, asynchronous): all regs = 8'h00, retired_o = 16'h0000 immediately, without waiting for a clock edge. While rst_n is low, wb_en_o=0, the bypass is disabled, and rd_data1_o/rd_data2_o read 8'h00.
- Reset deassertion: the first commit can occur on the first rising edge with rst_n high.
- Write latency: a value presented in cycle N is visible through the bypass in cycle N and from the array from cycle N+1.
- Read latency: 0 cycles (combinational from the address, regs and MEM/WB inputs).
- Back-to-back writes to the same register: the last one wins. A read in the same cycle sees the in-flight value.
- Reset asserted mid-cycle with writeReg_i=1: the write is discarded and the counter does not increment.
- No combinational path from rd_addr to wb_* outputs.

## Test plan
- Reset: drive rst_n=0 mid-cycle after writing r3=8'h5A -> regs all read 8'h00 and retired_o=0 before the next edge; wb_en_o=0.
- Source select: regD=2, writeReg=1, alu=8'h11, meDat=8'h22, data1=8'h33, imm=3'd5. Sweep opcode 4'h1/LD/LI/MOV -> r2 reads 8'h11, 8'h22, 8'h05, 8'h33 in the respective following cycles.
- Bypass: array r4=8'h00; in the same cycle write r4=8'hC3 with rd_addr1=rd_addr2=4 -> both reads return 8'hC3 in that cycle; the following cycle also returns 8'hC3 from the array.
- Gated write: writeReg=0, regD=1, alu=8'hFF -> r1 unchanged, no bypass, wb_en_o=0, retired_o unchanged.
- Counter wrap: preload with 65535 writes -> retired_o=16'hFFFF; one more write -> 16'h0000.
- Back-to-back: write r7=8'h01 then r7=8'h02 in consecutive cycles -> r7 reads 8'h02; retired_o increases by 2.
